// File: rtl/ysyx_24120013_regfile_pkg.sv
// Shared definitions for the write-back register file and its write queue.
// Width defaults are common with the execute stage.
package ysyx_24120013_regfile_pkg;

    localparam int unsigned AddrWidth = 5;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned QDepth    = 2;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/ysyx_24120013_regfile_if.sv
// Execute-stage / decode-stage view of the register file: write handshake,
// commit permission, two read ports and the pending-write count.
interface ysyx_24120013_regfile_if
    import ysyx_24120013_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddrWidth,
    parameter int unsigned DATA_WIDTH = DataWidth,
    parameter int unsigned QDEPTH     = QDepth
) ();

    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      commit_en;
    logic [ADDR_WIDTH-1:0]     raddr1;
    logic [ADDR_WIDTH-1:0]     raddr2;
    logic [DATA_WIDTH-1:0]     rdata1;
    logic [DATA_WIDTH-1:0]     rdata2;
    logic [$clog2(QDEPTH):0]   pending;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_en, raddr1, raddr2,
        input  wr_ready, rdata1, rdata2, pending
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_en, raddr1, raddr2,
        output wr_ready, rdata1, rdata2, pending
    );

endinterface

// File: rtl/ysyx_24120013_wq.sv
// In-order write queue; exposes the entries oldest-first (index 0 = head)
// with per-entry valid bits so the top level can bypass from it.
module ysyx_24120013_wq
    import ysyx_24120013_regfile_pkg::*;
#(
    parameter int unsigned Depth   = QDepth,
    parameter type         entry_t = wr_req_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  entry_t                   entry_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o,
    output entry_t                   head_o,
    output entry_t                   entries_o [Depth],
    output logic [Depth-1:0]         valid_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   head_q, head_d;
    logic [PtrW-1:0]   tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_en, pop_en;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[head_q];

    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    always_comb begin
        head_d  = pop_en  ? head_q + 1'b1 : head_q;
        tail_d  = push_en ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CntW'(push_en) - CntW'(pop_en);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: valid bits derived from count gate every use.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[tail_q] <= entry_i;
    end

    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            entries_o[i] = mem_q[PtrW'(head_q + PtrW'(i))];
            valid_o[i]   = (CntW'(i) < count_q);
        end
    end

endmodule

// File: rtl/ysyx_24120013_regfile.sv
// Register file with a queued write port and youngest-first bypass on both
// combinational read ports; x0 is hard-wired to zero.
module ysyx_24120013_regfile
    import ysyx_24120013_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AddrWidth,
    parameter int unsigned DATA_WIDTH = DataWidth,
    parameter int unsigned QDEPTH     = QDepth
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_24120013_regfile_if.slave bus_io
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

    wr_req_t                 req;
    wr_req_t                 head;
    wr_req_t                 entries [QDEPTH];
    logic [QDEPTH-1:0]       valid;
    logic                    full, empty;
    logic [$clog2(QDEPTH):0] count;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   regs_q [NumRegs];
    logic [DATA_WIDTH-1:0]   rdata1, rdata2;

    assign req.addr = bus_io.wr_addr;
    assign req.data = bus_io.wr_data;

    // Writes to x0 complete the handshake but are dropped here.
    assign push = bus_io.wr_valid && !full && (bus_io.wr_addr != '0);
    assign pop  = bus_io.commit_en && !empty;

    assign bus_io.wr_ready = !full;
    assign bus_io.pending  = count;

    ysyx_24120013_wq #(
        .Depth   (QDEPTH),
        .entry_t (wr_req_t)
    ) u_wq (
        .clk_i     (clk),
        .rst_i     (rst),
        .push_i    (push),
        .pop_i     (pop),
        .entry_i   (req),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .head_o    (head),
        .entries_o (entries),
        .valid_o   (valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else if (pop && head.addr != '0) begin
            regs_q[head.addr] <= head.data;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        rdata1 = regs_q[bus_io.raddr1];
        rdata2 = regs_q[bus_io.raddr2];
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (valid[i] && entries[i].addr == bus_io.raddr1) rdata1 = entries[i].data;
            if (valid[i] && entries[i].addr == bus_io.raddr2) rdata2 = entries[i].data;
        end
        if (bus_io.raddr1 == '0) rdata1 = '0;
        if (bus_io.raddr2 == '0) rdata2 = '0;
    end

    assign bus_io.rdata1 = rdata1;
    assign bus_io.rdata2 = rdata2;

endmodule

// File: tb/tb_ysyx_24120013_regfile.sv
// Directed bench for the queued register file: reset, bypass, stall,
// x0 discard, back-to-back streaming and asynchronous reset mid-operation.
module tb_ysyx_24120013_regfile;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ysyx_24120013_regfile_if #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .QDEPTH     (2)
    ) bus ();

    ysyx_24120013_regfile #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .QDEPTH     (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_wr(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.wr_valid = v;
        bus.wr_addr  = a;
        bus.wr_data  = d;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.raddr1 = a1;
        bus.raddr2 = a2;
        #1;
    endtask

    task automatic test_reset();
        set_rd(5'd0, 5'd0);
        total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rd1_x0 got=%h want=%h", bus.rdata1, 32'h0); end
        total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL rst_rd2_x0 got=%h want=%h", bus.rdata2, 32'h0); end
        set_rd(5'd1, 5'd31);
        total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rd1_x1 got=%h want=%h", bus.rdata1, 32'h0); end
        total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL rst_rd2_x31 got=%h want=%h", bus.rdata2, 32'h0); end
        set_rd(5'd31, 5'd1);
        total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL rst_rd1_x31 got=%h want=%h", bus.rdata1, 32'h0); end
        total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL rst_rd2_x1 got=%h want=%h", bus.rdata2, 32'h0); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", bus.wr_ready); end
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL rst_pending got=%0d want=0", bus.pending); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_commit();
        @(negedge clk);
        bus.commit_en = 1'b1;
        drive_wr(1'b1, 5'd5, 32'h1234);
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd5);
        total++; if (bus.rdata1 !== 32'h1234) begin bad++; $display("FAIL wc_bypass got=%h want=%h", bus.rdata1, 32'h1234); end
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL wc_pending1 got=%0d want=1", bus.pending); end
        @(negedge clk);
        set_rd(5'd5, 5'd5);
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL wc_pending0 got=%0d want=0", bus.pending); end
        total++; if (bus.rdata1 !== 32'h1234) begin bad++; $display("FAIL wc_array got=%h want=%h", bus.rdata1, 32'h1234); end
        total++; if (bus.rdata2 !== 32'h1234) begin bad++; $display("FAIL wc_array2 got=%h want=%h", bus.rdata2, 32'h1234); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.commit_en = 1'b0;
        drive_wr(1'b1, 5'd3, 32'hA);
        @(negedge clk);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL st_pending1 got=%0d want=1", bus.pending); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL st_ready1 got=%b want=1", bus.wr_ready); end
        drive_wr(1'b1, 5'd3, 32'hB);
        @(negedge clk);
        total++; if (bus.pending !== 2'd2) begin bad++; $display("FAIL st_pending2 got=%0d want=2", bus.pending); end
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL st_ready_full got=%b want=0", bus.wr_ready); end
        drive_wr(1'b1, 5'd4, 32'hC);
        set_rd(5'd3, 5'd4);
        total++; if (bus.rdata1 !== 32'hB) begin bad++; $display("FAIL st_youngest got=%h want=%h", bus.rdata1, 32'hB); end
        total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL st_no_incoming_bypass got=%h want=%h", bus.rdata2, 32'h0); end
        @(negedge clk);
        total++; if (bus.pending !== 2'd2) begin bad++; $display("FAIL st_hold got=%0d want=2", bus.pending); end
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL st_hold_ready got=%b want=0", bus.wr_ready); end
        bus.commit_en = 1'b1;
        @(negedge clk);
        set_rd(5'd3, 5'd4);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL st_retire1 got=%0d want=1", bus.pending); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL st_ready_again got=%b want=1", bus.wr_ready); end
        total++; if (bus.rdata1 !== 32'hB) begin bad++; $display("FAIL st_rd3_mid got=%h want=%h", bus.rdata1, 32'hB); end
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd4);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL st_swap got=%0d want=1", bus.pending); end
        total++; if (bus.rdata2 !== 32'hC) begin bad++; $display("FAIL st_rd4_bypass got=%h want=%h", bus.rdata2, 32'hC); end
        @(negedge clk);
        set_rd(5'd3, 5'd4);
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL st_drained got=%0d want=0", bus.pending); end
        total++; if (bus.rdata1 !== 32'hB) begin bad++; $display("FAIL st_x3_final got=%h want=%h", bus.rdata1, 32'hB); end
        total++; if (bus.rdata2 !== 32'hC) begin bad++; $display("FAIL st_x4_final got=%h want=%h", bus.rdata2, 32'hC); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        bus.commit_en = 1'b1;
        drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL x0_pending got=%0d want=0", bus.pending); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b want=1", bus.wr_ready); end
        total++; if (bus.rdata1 !== 32'h0) begin bad++; $display("FAIL x0_rd1 got=%h want=%h", bus.rdata1, 32'h0); end
        total++; if (bus.rdata2 !== 32'h0) begin bad++; $display("FAIL x0_rd2 got=%h want=%h", bus.rdata2, 32'h0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.commit_en = 1'b0;
        drive_wr(1'b1, 5'd10, 32'd1);
        @(negedge clk);
        drive_wr(1'b1, 5'd11, 32'd2);
        @(negedge clk);
        total++; if (bus.pending !== 2'd2) begin bad++; $display("FAIL bb_full got=%0d want=2", bus.pending); end
        drive_wr(1'b1, 5'd12, 32'd3);
        bus.commit_en = 1'b1;
        @(negedge clk);
        set_rd(5'd12, 5'd10);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL bb_p_a got=%0d want=1", bus.pending); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL bb_ready_a got=%b want=1", bus.wr_ready); end
        total++; if (bus.rdata1 !== 32'd0) begin bad++; $display("FAIL bb_x12_not_yet got=%h want=%h", bus.rdata1, 32'd0); end
        total++; if (bus.rdata2 !== 32'd1) begin bad++; $display("FAIL bb_x10_array got=%h want=%h", bus.rdata2, 32'd1); end
        @(negedge clk);
        set_rd(5'd12, 5'd11);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL bb_p_b got=%0d want=1", bus.pending); end
        total++; if (bus.rdata1 !== 32'd3) begin bad++; $display("FAIL bb_x12_byp got=%h want=%h", bus.rdata1, 32'd3); end
        total++; if (bus.rdata2 !== 32'd2) begin bad++; $display("FAIL bb_x11_array got=%h want=%h", bus.rdata2, 32'd2); end
        drive_wr(1'b1, 5'd10, 32'd5);
        @(negedge clk);
        set_rd(5'd10, 5'd12);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL bb_p_c got=%0d want=1", bus.pending); end
        total++; if (bus.rdata1 !== 32'd5) begin bad++; $display("FAIL bb_x10_byp got=%h want=%h", bus.rdata1, 32'd5); end
        drive_wr(1'b1, 5'd13, 32'd4);
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd13, 5'd10);
        total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL bb_p_d got=%0d want=1", bus.pending); end
        total++; if (bus.rdata1 !== 32'd4) begin bad++; $display("FAIL bb_x13_byp got=%h want=%h", bus.rdata1, 32'd4); end
        @(negedge clk);
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL bb_drained got=%0d want=0", bus.pending); end
        set_rd(5'd10, 5'd11);
        total++; if (bus.rdata1 !== 32'd5) begin bad++; $display("FAIL bb_x10_final got=%h want=%h", bus.rdata1, 32'd5); end
        total++; if (bus.rdata2 !== 32'd2) begin bad++; $display("FAIL bb_x11_final got=%h want=%h", bus.rdata2, 32'd2); end
        set_rd(5'd12, 5'd13);
        total++; if (bus.rdata1 !== 32'd3) begin bad++; $display("FAIL bb_x12_final got=%h want=%h", bus.rdata1, 32'd3); end
        total++; if (bus.rdata2 !== 32'd4) begin bad++; $display("FAIL bb_x13_final got=%h want=%h", bus.rdata2, 32'd4); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.commit_en = 1'b0;
        drive_wr(1'b1, 5'd20, 32'd7);
        @(negedge clk);
        drive_wr(1'b1, 5'd21, 32'd8);
        @(negedge clk);
        drive_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd20, 5'd21);
        total++; if (bus.rdata1 !== 32'd7) begin bad++; $display("FAIL rm_pre_x20 got=%h want=%h", bus.rdata1, 32'd7); end
        total++; if (bus.rdata2 !== 32'd8) begin bad++; $display("FAIL rm_pre_x21 got=%h want=%h", bus.rdata2, 32'd8); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL rm_pending got=%0d want=0", bus.pending); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", bus.wr_ready); end
        total++; if (bus.rdata1 !== 32'd0) begin bad++; $display("FAIL rm_x20 got=%h want=%h", bus.rdata1, 32'd0); end
        total++; if (bus.rdata2 !== 32'd0) begin bad++; $display("FAIL rm_x21 got=%h want=%h", bus.rdata2, 32'd0); end
        rst = 1'b0;
        bus.commit_en = 1'b1;
        set_rd(5'd5, 5'd3);
        total++; if (bus.rdata1 !== 32'd0) begin bad++; $display("FAIL rm_x5_cleared got=%h want=%h", bus.rdata1, 32'd0); end
        total++; if (bus.rdata2 !== 32'd0) begin bad++; $display("FAIL rm_x3_cleared got=%h want=%h", bus.rdata2, 32'd0); end
        @(negedge clk);
        @(negedge clk);
        set_rd(5'd20, 5'd21);
        total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL rm_pending_after got=%0d want=0", bus.pending); end
        total++; if (bus.rdata1 !== 32'd0) begin bad++; $display("FAIL rm_x20_after got=%h want=%h", bus.rdata1, 32'd0); end
        total++; if (bus.rdata2 !== 32'd0) begin bad++; $display("FAIL rm_x21_after got=%h want=%h", bus.rdata2, 32'd0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.commit_en = 1'b0;
        drive_wr(1'b0, 5'd0, 32'h0);
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        #1;
        test_reset();
        test_write_commit();
        test_stall();
        test_x0();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
